traffic_controller: RTL and testbench



---
 rtl/traffic_pkg.sv | 30 +++
 rtl/phase_timer.sv | 29 ++
 rtl/traffic_controller.sv | 122 ++++++++++++
 tb/tb_traffic_controller.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and constants for the intersection traffic controller.
package traffic_pkg;

    // Phase encoding, also driven on the phase output.
    typedef enum logic [1:0] {
        ALL_RED = 2'd0,
        UPDOWN  = 2'd1,
        TURN    = 2'd2,
        PED     = 2'd3
    } phase_t;

    // Default phase durations in clock cycles.
    localparam int DEFAULT_GREEN_CYCLES = 8;
    localparam int DEFAULT_TURN_CYCLES  = 4;
    localparam int DEFAULT_PED_CYCLES   = 6;
    localparam int DEFAULT_CLEAR_CYCLES = 2;

    // The timer only ever holds duration-1, so $clog2 of the longest
    // duration is enough; a register still needs at least one bit.
    function automatic int timer_width(input int green, input int turn,
                                       input int ped, input int clear);
        int longest;
        longest = green;
        if (turn > longest) longest = turn;
        if (ped > longest) longest = ped;
        if (clear > longest) longest = clear;
        return (longest <= 1) ? 1 : $clog2(longest);
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Down-counter that measures how long the current phase has lasted.
// It is loaded with duration-1 on phase entry and reports expiry at zero.
module phase_timer #(
    parameter int               WIDTH       = 3,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             expired
);

    logic [WIDTH-1:0] count;

    // Load on request, otherwise count down and park at zero instead of wrapping.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= RESET_VALUE;
        end else if (load) begin
            count <= load_value;
        end else if (count != '0) begin
            count <= count - WIDTH'(1);
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/traffic_controller.sv
// Intersection phase sequencer: UPDOWN green by default, TURN and PED
// served only on latched requests, every green separated by ALL_RED.
module traffic_controller
    import traffic_pkg::*;
#(
    parameter int GREEN_CYCLES = DEFAULT_GREEN_CYCLES,
    parameter int TURN_CYCLES  = DEFAULT_TURN_CYCLES,
    parameter int PED_CYCLES   = DEFAULT_PED_CYCLES,
    parameter int CLEAR_CYCLES = DEFAULT_CLEAR_CYCLES
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       ped_button,
    input  logic       turn_sensor,
    output logic       pedestrian_green,
    output logic       up_green,
    output logic       down_green,
    output logic       turn_green,
    output logic [1:0] phase,
    output logic       ped_waiting
);

    localparam int TW = timer_width(GREEN_CYCLES, TURN_CYCLES, PED_CYCLES, CLEAR_CYCLES);

    localparam logic [TW-1:0] GREEN_LOAD = TW'(GREEN_CYCLES - 1);
    localparam logic [TW-1:0] TURN_LOAD  = TW'(TURN_CYCLES - 1);
    localparam logic [TW-1:0] PED_LOAD   = TW'(PED_CYCLES - 1);
    localparam logic [TW-1:0] CLEAR_LOAD = TW'(CLEAR_CYCLES - 1);

    phase_t        state;
    phase_t        next_green;
    phase_t        exit_to;
    phase_t        target_after;
    logic          ped_pending;
    logic          turn_pending;
    logic          timer_expired;
    logic [TW-1:0] timer_value;
    logic          enter_ped;
    logic          enter_turn;

    // Every expiry starts a new interval (or restarts UPDOWN), so the timer
    // is reloaded exactly when it reaches zero.
    phase_timer #(
        .WIDTH       (TW),
        .RESET_VALUE (CLEAR_LOAD)
    ) timer_inst (
        .clock      (clock),
        .reset      (reset),
        .load       (timer_expired),
        .load_value (timer_value),
        .expired    (timer_expired)
    );

    // Decide where the current phase goes on expiry and which green follows ALL_RED.
    always_comb begin
        exit_to      = state;
        target_after = next_green;
        case (state)
            ALL_RED: exit_to = next_green;
            UPDOWN: begin
                if (turn_pending || ped_pending) begin
                    exit_to      = ALL_RED;
                    target_after = turn_pending ? TURN : PED;
                end
            end
            TURN: begin
                exit_to      = ALL_RED;
                target_after = ped_pending ? PED : UPDOWN;
            end
            PED: begin
                exit_to      = ALL_RED;
                target_after = UPDOWN;
            end
            default: exit_to = ALL_RED;
        endcase
    end

    // Pick the reload value for whichever interval is entered next.
    always_comb begin
        timer_value = CLEAR_LOAD;
        case (exit_to)
            ALL_RED: timer_value = CLEAR_LOAD;
            UPDOWN:  timer_value = GREEN_LOAD;
            TURN:    timer_value = TURN_LOAD;
            PED:     timer_value = PED_LOAD;
            default: timer_value = CLEAR_LOAD;
        endcase
    end

    assign enter_ped  = timer_expired && (exit_to == PED);
    assign enter_turn = timer_expired && (exit_to == TURN);

    // Phase register, green decode and request latches; next_green resets to
    // UPDOWN as if PED had just been served.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state            <= ALL_RED;
            next_green       <= UPDOWN;
            ped_pending      <= 1'b0;
            turn_pending     <= 1'b0;
            pedestrian_green <= 1'b0;
            up_green         <= 1'b0;
            down_green       <= 1'b0;
            turn_green       <= 1'b0;
        end else begin
            if (timer_expired) begin
                state            <= exit_to;
                next_green       <= target_after;
                pedestrian_green <= (exit_to == PED);
                up_green         <= (exit_to == UPDOWN);
                down_green       <= (exit_to == UPDOWN);
                turn_green       <= (exit_to == TURN);
            end
            ped_pending  <= enter_ped  ? 1'b0 : (ped_pending  | ped_button);
            turn_pending <= enter_turn ? 1'b0 : (turn_pending | turn_sensor);
        end
    end

    assign phase       = state;
    assign ped_waiting = ped_pending;

endmodule

// File: tb/tb_traffic_controller.sv
// Self-checking bench for traffic_controller: vector tables, corner-case
// sequences and a random run against a cycle-count reference model.
module tb_traffic_controller;
    import traffic_pkg::*;

    localparam int G_CYC = 8;
    localparam int T_CYC = 4;
    localparam int P_CYC = 6;
    localparam int C_CYC = 2;

    logic       clock;
    logic       reset;
    logic       ped_button;
    logic       turn_sensor;
    logic       pedestrian_green;
    logic       up_green;
    logic       down_green;
    logic       turn_green;
    logic [1:0] phase;
    logic       ped_waiting;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic   do_reset;
        logic   ped;
        logic   turn;
        phase_t exp_phase;
        logic   exp_wait;
    } vec_t;

    vec_t vectors[$];

    phase_t m_phase;
    phase_t m_target;
    int     m_elapsed;
    logic   m_ped;
    logic   m_turn;

    traffic_controller #(
        .GREEN_CYCLES (G_CYC),
        .TURN_CYCLES  (T_CYC),
        .PED_CYCLES   (P_CYC),
        .CLEAR_CYCLES (C_CYC)
    ) dut (
        .clock            (clock),
        .reset            (reset),
        .ped_button       (ped_button),
        .turn_sensor      (turn_sensor),
        .pedestrian_green (pedestrian_green),
        .up_green         (up_green),
        .down_green       (down_green),
        .turn_green       (turn_green),
        .phase            (phase),
        .ped_waiting      (ped_waiting)
    );

    // Free-running clock
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Watchdog so the run always ends
    initial begin
        #400000;
        $display("[TB] FAIL watchdog: simulation still running, expected to have finished");
        $fatal(1, "[TB] watchdog expired");
    end

    // Expected greens {ped, up, down, turn} for a phase
    function automatic logic [3:0] greens_for(input phase_t p);
        case (p)
            UPDOWN:  return 4'b0110;
            TURN:    return 4'b0001;
            PED:     return 4'b1000;
            default: return 4'b0000;
        endcase
    endfunction

    function automatic int duration(input phase_t p);
        case (p)
            UPDOWN:  return G_CYC;
            TURN:    return T_CYC;
            PED:     return P_CYC;
            default: return C_CYC;
        endcase
    endfunction

    function automatic void add_run(input logic rst, input logic ped, input logic turn,
                                    input phase_t ph, input logic w, input int n);
        vec_t v;
        for (int i = 0; i < n; i++) begin
            v.do_reset  = rst && (i == 0);
            v.ped       = ped;
            v.turn      = turn;
            v.exp_phase = ph;
            v.exp_wait  = w;
            vectors.push_back(v);
        end
    endfunction

    // Reference model: tracks cycles spent in the current phase and the
    // request flags, applying the phase rules once per clock.
    function automatic void model_reset();
        m_phase   = ALL_RED;
        m_target  = UPDOWN;
        m_elapsed = 0;
        m_ped     = 1'b0;
        m_turn    = 1'b0;
    endfunction

    function automatic void model_step(input logic ped, input logic turn);
        phase_t nxt;
        nxt = m_phase;
        m_elapsed++;
        if (m_elapsed >= duration(m_phase)) begin
            case (m_phase)
                ALL_RED: nxt = m_target;
                UPDOWN: begin
                    if (m_turn || m_ped) begin
                        nxt      = ALL_RED;
                        m_target = m_turn ? TURN : PED;
                    end
                end
                TURN: begin
                    nxt      = ALL_RED;
                    m_target = m_ped ? PED : UPDOWN;
                end
                default: begin
                    nxt      = ALL_RED;
                    m_target = UPDOWN;
                end
            endcase
            m_elapsed = 0;
        end
        m_ped  = (nxt == PED  && m_phase != PED)  ? 1'b0 : (m_ped  | ped);
        m_turn = (nxt == TURN && m_phase != TURN) ? 1'b0 : (m_turn | turn);
        m_phase = nxt;
    endfunction

    task automatic applyStimulus(input logic ped, input logic turn);
        ped_button  = ped;
        turn_sensor = turn;
        @(posedge clock);
        #1;
    endtask

    task automatic checkOutput(input string name, input phase_t exp_phase, input logic exp_wait);
        logic [3:0] exp_g;
        logic [3:0] got_g;
        exp_g = greens_for(exp_phase);
        got_g = {pedestrian_green, up_green, down_green, turn_green};
        total++;
        if (phase !== exp_phase || got_g !== exp_g || ped_waiting !== exp_wait) begin
            bad++;
            $display("[TB] FAIL %s: got phase=%0d greens=%b wait=%b, expected phase=%0d greens=%b wait=%b",
                     name, phase, got_g, ped_waiting, exp_phase, exp_g, exp_wait);
        end
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        ped_button  = 1'b0;
        turn_sensor = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        checkOutput("reset_state", ALL_RED, 1'b0);
        reset = 1'b0;
    endtask

    initial begin
        reset       = 1'b1;
        ped_button  = 1'b0;
        turn_sensor = 1'b0;

        // Idle: two cycles all-red then continuous UPDOWN
        add_run(1, 0, 0, ALL_RED, 0, 1);
        add_run(0, 0, 0, UPDOWN,  0, 44);
        // Pedestrian press in the third UPDOWN cycle
        add_run(1, 0, 0, ALL_RED, 0, 1);
        add_run(0, 0, 0, UPDOWN,  0, 3);
        add_run(0, 1, 0, UPDOWN,  1, 1);
        add_run(0, 0, 0, UPDOWN,  1, 4);
        add_run(0, 0, 0, ALL_RED, 1, 2);
        add_run(0, 0, 0, PED,     0, 6);
        add_run(0, 0, 0, ALL_RED, 0, 2);
        add_run(0, 0, 0, UPDOWN,  0, 4);
        // Turn and pedestrian together
        add_run(1, 0, 0, ALL_RED, 0, 1);
        add_run(0, 0, 0, UPDOWN,  0, 3);
        add_run(0, 1, 1, UPDOWN,  1, 1);
        add_run(0, 0, 0, UPDOWN,  1, 4);
        add_run(0, 0, 0, ALL_RED, 1, 2);
        add_run(0, 0, 0, TURN,    1, 4);
        add_run(0, 0, 0, ALL_RED, 1, 2);
        add_run(0, 0, 0, PED,     0, 6);
        add_run(0, 0, 0, ALL_RED, 0, 2);
        add_run(0, 0, 0, UPDOWN,  0, 3);

        for (int i = 0; i < vectors.size(); i++) begin
            if (vectors[i].do_reset) do_reset();
            applyStimulus(vectors[i].ped, vectors[i].turn);
            checkOutput($sformatf("vec%0d", i), vectors[i].exp_phase, vectors[i].exp_wait);
        end

        // Press on the PED entry edge is absorbed: no second PED
        do_reset();
        for (int k = 1; k <= 40; k++) begin
            applyStimulus((k == 5) || (k == 12), 1'b0);
            if (k == 12) checkOutput("absorb_entry", PED, 1'b0);
            if (k == 20) checkOutput("absorb_back_updown", UPDOWN, 1'b0);
            if (k == 28) checkOutput("absorb_reload", UPDOWN, 1'b0);
            if (k == 40) checkOutput("absorb_no_second_ped", UPDOWN, 1'b0);
        end

        // Press during PED earns a second PED after the next UPDOWN
        do_reset();
        for (int k = 1; k <= 36; k++) begin
            applyStimulus((k == 5) || (k == 14), 1'b0);
            if (k == 14) checkOutput("repress_latched", PED, 1'b1);
            if (k == 27) checkOutput("repress_updown_end", UPDOWN, 1'b1);
            if (k == 28) checkOutput("repress_clear", ALL_RED, 1'b1);
            if (k == 30) checkOutput("repress_second_ped", PED, 1'b0);
            if (k == 35) checkOutput("repress_ped_last", PED, 1'b0);
            if (k == 36) checkOutput("repress_after_ped", ALL_RED, 1'b0);
        end

        // Asynchronous reset in the middle of TURN
        do_reset();
        for (int k = 1; k <= 13; k++) applyStimulus(1'b0, (k == 5));
        checkOutput("mid_turn", TURN, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        checkOutput("async_reset", ALL_RED, 1'b0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            applyStimulus(1'b0, 1'b0);
            if (k == 1)  checkOutput("post_reset_red", ALL_RED, 1'b0);
            if (k == 2)  checkOutput("post_reset_updown", UPDOWN, 1'b0);
            if (k == 12) checkOutput("post_reset_no_turn", UPDOWN, 1'b0);
        end

        // Random requests against the reference model
        do_reset();
        model_reset();
        for (int n = 0; n < 10000; n++) begin
            logic rp;
            logic rt;
            rp = ($urandom_range(0, 15) == 0);
            rt = ($urandom_range(0, 15) == 0);
            applyStimulus(rp, rt);
            model_step(rp, rt);
            checkOutput("random", m_phase, m_ped);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
